// File: rtl/pmic_pkg.sv
// Shared definitions for the PMod MIC capture front-end: FSM encoding and ADC frame geometry.
package pmic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SHIFT = 2'd2,
        STOP  = 2'd3
    } pmic_state_t;

    localparam int PMIC_FRAME_BITS = 16;
    localparam int PMIC_LEAD_ZEROS = 4;
    localparam int PMIC_BW         = 12;

endpackage

// File: rtl/pmic_tick_gen.sv
// Sample-rate tick: reload-down-counter held at full count while disabled, one-cycle tick at zero.
// First tick lands CLKS_PER_SAMPLE-1 cycles after i_en rises, then every CLKS_PER_SAMPLE cycles.
module pmic_tick_gen #(
    parameter int CLKS_PER_SAMPLE = 2500
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = $clog2(CLKS_PER_SAMPLE);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_SAMPLE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_en || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tick = i_en && (cnt_q == '0);

endmodule

// File: rtl/pmic_capture.sv
// PMod MIC ADC front-end: CS/SCLK generation, 16-bit frame deserialise, one-cycle FIFO write per sample.
// Write strobe lands 33*SCLK_DIV+1 cycles after a tick; a full FIFO drops the sample and sets o_ovr. PMIC_ZERO_CHECK_EN adds leading-zero checking.
module pmic_capture
    import pmic_pkg::*;
#(
    parameter int BW              = PMIC_BW,
    parameter int CLKS_PER_SAMPLE = 2500,
    parameter int SCLK_DIV        = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic          i_fifo_full,
    output logic          o_csn,
    output logic          o_sck,
    input  logic          i_miso,
    output logic          o_wr,
    output logic [BW-1:0] o_data,
    output logic [15:0]   o_count,
    output logic          o_ovr,
    output logic          o_err
);

    if (CLKS_PER_SAMPLE < 34 * SCLK_DIV + 2) begin : g_bad_rate
        $error("pmic_capture: CLKS_PER_SAMPLE must be >= 34*SCLK_DIV+2");
    end
    if (SCLK_DIV < 2) begin : g_bad_div
        $error("pmic_capture: SCLK_DIV must be >= 2");
    end
    if (BW != PMIC_BW) begin : g_bad_bw
        $error("pmic_capture: BW is fixed by the ADC at 12");
    end

    // The leading-zero bits only need to be retained when they are checked.
`ifdef PMIC_ZERO_CHECK_EN
    localparam int SHIFT_W = PMIC_FRAME_BITS;
`else
    localparam int SHIFT_W = PMIC_BW;
`endif
    localparam int HW  = $clog2(SCLK_DIV);
    localparam int BCW = $clog2(PMIC_FRAME_BITS);
    localparam logic [HW-1:0]  HP_LAST  = HW'(SCLK_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(PMIC_FRAME_BITS - 1);

    pmic_state_t        state_q, state_d;
    logic [HW-1:0]      hp_q, hp_d;
    logic               phase_q, phase_d;
    logic [BCW-1:0]     bit_q, bit_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [BW-1:0]      data_q, data_d;
    logic [15:0]        count_q, count_d;
    logic               ovr_q, ovr_d;
    logic               err_q, err_d;
    logic               m_q;
    logic               tick, hp_end, bad_frame, csn, sck, wr, wr_ok;

    pmic_tick_gen #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
    ) u_tick (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (i_en),
        .o_tick(tick)
    );

    assign hp_end = (hp_q == HP_LAST);

`ifdef PMIC_ZERO_CHECK_EN
    assign bad_frame = (shift_q[SHIFT_W-1 -: PMIC_LEAD_ZEROS] != '0);
`else
    assign bad_frame = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        count_d = count_q;
        ovr_d   = ovr_q;
        err_d   = err_q;
        csn     = 1'b1;
        sck     = 1'b1;
        wr      = 1'b0;
        case (state_q)
            IDLE: begin
                hp_d    = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                if (tick) begin
                    state_d = START;
                end
            end
            START: begin
                csn  = 1'b0;
                hp_d = hp_end ? '0 : hp_q + HW'(1);
                if (hp_end) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                csn  = 1'b0;
                sck  = phase_q;
                hp_d = hp_end ? '0 : hp_q + HW'(1);
                if (hp_end) begin
                    phase_d = ~phase_q;
                    // Sample on the last low cycle, just before SCLK rises.
                    if (!phase_q) begin
                        shift_d = {shift_q[SHIFT_W-2:0], m_q};
                    end else begin
                        bit_d = (bit_q == BIT_LAST) ? '0 : bit_q + BCW'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                state_d = IDLE;
                if (bad_frame) begin
                    err_d = 1'b1;
                end
                if (i_fifo_full) begin
                    ovr_d = 1'b1;
                end else if (!bad_frame) begin
                    wr      = 1'b1;
                    data_d  = shift_q[BW-1:0];
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            hp_q    <= '0;
            phase_q <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            count_q <= '0;
            ovr_q   <= 1'b0;
            err_q   <= 1'b0;
            m_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
            err_q   <= err_d;
            m_q     <= i_miso;
        end
    end

    // The write lands in the STOP cycle itself, so the sample is forwarded alongside the strobe.
    assign wr_ok   = wr && !i_rst;
    assign o_wr    = wr_ok;
    assign o_data  = wr_ok ? shift_q[BW-1:0] : data_q;
    assign o_csn   = csn;
    assign o_sck   = sck;
    assign o_count = count_q;
    assign o_ovr   = ovr_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_pmic_capture.sv
// Bench for pmic_capture: ADC serial model, write scoreboard, frame table and reset/enable corner sequences.
module tb_pmic_capture;

    localparam int CPS    = 100;
    localparam int T      = 2;
    localparam int WR_LAT = 33 * T + 1;

    logic        clk = 1'b0;
    logic        rst, en, full, miso;
    logic        csn, sck, wr, ovr, err;
    logic [11:0] data;
    logic [15:0] count;

    always #5 clk = ~clk;

    pmic_capture #(
        .BW(12),
        .CLKS_PER_SAMPLE(CPS),
        .SCLK_DIV(T)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_fifo_full(full),
        .o_csn      (csn),
        .o_sck      (sck),
        .i_miso     (miso),
        .o_wr       (wr),
        .o_data     (data),
        .o_count    (count),
        .o_ovr      (ovr),
        .o_err      (err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ADC model: next bit appears on each SCLK falling edge while CS is low.
    logic [15:0] adc_q[$];
    logic [15:0] frame = 16'h0;
    logic        prev_csn = 1'b1;
    logic        prev_sck = 1'b1;
    int          idx = 15;
    int          falls = 0;
    int          last_falls = 0;
    int          nframes = 0;

    always @(negedge clk) begin
        if (prev_csn && !csn) begin
            frame = 16'h0;
            if (adc_q.size() != 0) frame = adc_q.pop_front();
            idx   = 15;
            falls = 0;
            nframes++;
        end
        if (!csn && prev_sck && !sck) begin
            if (idx >= 0) miso = frame[idx];
            idx--;
            falls++;
        end
        if (!prev_csn && csn) last_falls = falls;
        prev_csn = csn;
        prev_sck = sck;
    end

    // Scoreboard: every strobe must match the oldest pending expected sample.
    logic [11:0] exp_q[$];
    int          wr_cyc_q[$];

    always @(negedge clk) begin
        if (wr === 1'b1) begin
            wr_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("wr_unexpected", wr, 0);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                check("wr_data", data, e);
            end
        end
    end

    task automatic wait_csn(input logic lvl, input string nm);
        int n = 0;
        while (csn !== lvl && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(nm, csn, lvl);
    endtask

    typedef struct {
        logic [15:0] val;
        logic        fifo_full;
        logic        exp_wr;
        logic [11:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int en_cyc, rel_cyc, n0, m_count, exp_writes;
        logic m_ovr, m_err;

        vecs[0] = '{16'h0ABC, 1'b0, 1'b1, 12'hABC};
        vecs[1] = '{16'h0000, 1'b0, 1'b1, 12'h000};
        vecs[2] = '{16'h0FFF, 1'b0, 1'b1, 12'hFFF};
        vecs[3] = '{16'h0555, 1'b0, 1'b1, 12'h555};
        vecs[4] = '{16'h0AAA, 1'b0, 1'b1, 12'hAAA};
        vecs[5] = '{16'h0001, 1'b0, 1'b1, 12'h001};
        vecs[6] = '{16'h0777, 1'b1, 1'b0, 12'h001};
        vecs[7] = '{16'h0123, 1'b0, 1'b1, 12'h123};
`ifdef PMIC_ZERO_CHECK_EN
        vecs[8] = '{16'h1234, 1'b0, 1'b0, 12'h123};
        vecs[9] = '{16'hF456, 1'b1, 1'b0, 12'h123};
`else
        vecs[8] = '{16'h1234, 1'b0, 1'b1, 12'h234};
        vecs[9] = '{16'hF456, 1'b1, 1'b0, 12'h234};
`endif

        rst  = 1'b1;
        en   = 1'b0;
        full = 1'b0;
        miso = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_csn", csn, 1);
        check("rst_sck", sck, 1);
        check("rst_wr", wr, 0);
        check("rst_data", data, 0);
        check("rst_count", count, 0);
        check("rst_ovr", ovr, 0);
        check("rst_err", err, 0);

        rst = 1'b0;
        repeat (150) @(negedge clk);
        check("no_frame_while_disabled", nframes, 0);

        en     = 1'b1;
        en_cyc = cyc;
        m_count = 0;
        m_ovr   = 1'b0;
        m_err   = 1'b0;
        exp_writes = 0;
        for (int i = 0; i < 10; i++) begin
            adc_q.push_back(vecs[i].val);
            if (vecs[i].exp_wr) begin
                exp_q.push_back(vecs[i].exp_data);
                exp_writes++;
            end
            wait_csn(1'b0, $sformatf("frame%0d_start", i));
            if (i == 0) check("first_csn_fall_delay", cyc - en_cyc, CPS);
            full = vecs[i].fifo_full;
            wait_csn(1'b1, $sformatf("frame%0d_end", i));
            @(negedge clk);
            full = 1'b0;
            if (vecs[i].exp_wr) m_count++;
            if (vecs[i].fifo_full) m_ovr = 1'b1;
`ifdef PMIC_ZERO_CHECK_EN
            if (vecs[i].val[15:12] != 4'h0) m_err = 1'b1;
`endif
            if (i == 0) check("sclk_falls_per_frame", last_falls, 16);
            check($sformatf("count_%0d", i), count, m_count);
            check($sformatf("ovr_%0d", i), ovr, m_ovr);
            check($sformatf("err_%0d", i), err, m_err);
            check($sformatf("data_hold_%0d", i), data, vecs[i].exp_data);
        end

        check("table_write_count", wr_cyc_q.size(), exp_writes);
        if (wr_cyc_q.size() >= 6) begin
            check("first_wr_delay", wr_cyc_q[0] - en_cyc, CPS - 1 + WR_LAT);
            for (int k = 1; k < 6; k++)
                check($sformatf("wr_spacing_%0d", k), wr_cyc_q[k] - wr_cyc_q[k-1], CPS);
        end

        // Reset eight bits into a frame: frame abandoned, no strobe.
        adc_q.push_back(16'h0ABC);
        wait_csn(1'b0, "rst_frame_start");
        repeat (T + 8 * 2 * T) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_csn", csn, 1);
        check("midrst_sck", sck, 1);
        check("midrst_wr", wr, 0);
        check("midrst_data", data, 0);
        check("midrst_count", count, 0);
        check("midrst_ovr", ovr, 0);
        check("midrst_err", err, 0);
        rst     = 1'b0;
        rel_cyc = cyc;

        // Drop enable mid-frame: this frame still completes, nothing follows.
        adc_q.push_back(16'h0321);
        exp_q.push_back(12'h321);
        wait_csn(1'b0, "post_rst_frame_start");
        check("post_rst_csn_fall_delay", cyc - rel_cyc, CPS);
        repeat (20) @(negedge clk);
        en = 1'b0;
        wait_csn(1'b1, "en_drop_frame_end");
        @(negedge clk);
        check("en_drop_count", count, 1);
        check("en_drop_data", data, 12'h321);
        n0 = nframes;
        repeat (300) @(negedge clk);
        check("no_frame_after_en_low", nframes, n0);
        check("csn_idle_after_en_low", csn, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
